// File: rtl/line_clear_pkg.sv
// Shared types and geometry helpers for the playfield line-clear engine.
package line_clear_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SHIFT,
    ST_CLEAR,
    ST_DONE
  } lce_state_e;

  localparam int EMPTY_CELL = 0;

  function automatic int calc_row_words(input int cols, input int nbytes);
    return (cols + nbytes - 1) / nbytes;
  endfunction

  // Byte enables for the last word of a row; bytes past the last column are padding.
  function automatic logic [31:0] calc_last_be(input int cols, input int nbytes);
    logic [31:0] m;
    int          rem;
    m   = '0;
    rem = cols - (calc_row_words(cols, nbytes) - 1) * nbytes;
    for (int i = 0; i < 32; i++) begin
      if (i < rem) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/line_clear_addr_gen.sv
// Independent read and write row/word cursors mapped onto playfield RAM addresses.
module line_clear_addr_gen #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int BASE_ADDR     = 0,
  parameter int ROW_WORDS     = 3,
  parameter int ROW_W         = 5,
  parameter int WORD_W        = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_rd_load,
  input  logic [ROW_W-1:0]         i_rd_row,
  input  logic                     i_rd_adv,
  input  logic                     i_rd_wrap,
  input  logic                     i_wr_load,
  input  logic [ROW_W-1:0]         i_wr_row,
  input  logic                     i_wr_adv,
  input  logic                     i_wr_wrap,
  output logic [ROW_W-1:0]         o_rd_row,
  output logic                     o_rd_last,
  output logic [ROW_W-1:0]         o_wr_row,
  output logic                     o_wr_last,
  output logic [ADDRESS_WIDTH-1:0] o_raddr,
  output logic [ADDRESS_WIDTH-1:0] o_waddr
);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(ROW_WORDS - 1);

  logic [ROW_W-1:0]  r_rd_row, r_wr_row;
  logic [WORD_W-1:0] r_rd_word, r_wr_word;

  // A wrap moves to the row above (lower index) because copies run bottom-up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_row  <= '0;
      r_rd_word <= '0;
      r_wr_row  <= '0;
      r_wr_word <= '0;
    end else begin
      if (i_rd_load) begin
        r_rd_row  <= i_rd_row;
        r_rd_word <= '0;
      end else if (i_rd_adv) begin
        if (r_rd_word == LAST_WORD) begin
          r_rd_word <= '0;
          if (i_rd_wrap) r_rd_row <= r_rd_row - ROW_W'(1);
        end else begin
          r_rd_word <= r_rd_word + WORD_W'(1);
        end
      end
      if (i_wr_load) begin
        r_wr_row  <= i_wr_row;
        r_wr_word <= '0;
      end else if (i_wr_adv) begin
        if (r_wr_word == LAST_WORD) begin
          r_wr_word <= '0;
          if (i_wr_wrap) r_wr_row <= r_wr_row - ROW_W'(1);
        end else begin
          r_wr_word <= r_wr_word + WORD_W'(1);
        end
      end
    end
  end

  assign o_rd_row  = r_rd_row;
  assign o_wr_row  = r_wr_row;
  assign o_rd_last = (r_rd_word == LAST_WORD);
  assign o_wr_last = (r_wr_word == LAST_WORD);
  assign o_raddr   = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(r_rd_row) * ADDRESS_WIDTH'(ROW_WORDS)
                   + ADDRESS_WIDTH'(r_rd_word);
  assign o_waddr   = ADDRESS_WIDTH'(BASE_ADDR) + ADDRESS_WIDTH'(r_wr_row) * ADDRESS_WIDTH'(ROW_WORDS)
                   + ADDRESS_WIDTH'(r_wr_word);

endmodule

// File: rtl/line_clear_engine.sv
// Scans the playfield bottom-up, removes full rows by shifting the rows above down one
// and blanking row 0, then rescans the same row.
module line_clear_engine
  import line_clear_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int BYTE_WIDTH    = 8,
  parameter int NUM_BYTES     = 4,
  parameter int BASE_ADDR     = 0,
  parameter int ROWS          = 20,
  parameter int COLS          = 10
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic [$clog2(ROWS+1)-1:0]       lines_cleared,
  input  logic                            mem_gnt,
  output logic [ADDRESS_WIDTH-1:0]        raddr,
  input  logic [BYTE_WIDTH*NUM_BYTES-1:0] q,
  output logic                            we,
  output logic [ADDRESS_WIDTH-1:0]        waddr,
  output logic [NUM_BYTES-1:0]            be,
  output logic [BYTE_WIDTH*NUM_BYTES-1:0] wdata
);

  localparam int ROW_WORDS = calc_row_words(COLS, NUM_BYTES);
  localparam int ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WORD_W    = $clog2(ROW_WORDS + 1);
  localparam int LC_W      = $clog2(ROWS + 1);
  localparam logic [NUM_BYTES-1:0] LAST_BE = NUM_BYTES'(calc_last_be(COLS, NUM_BYTES));
  localparam logic [NUM_BYTES-1:0] FULL_BE = '1;
  localparam logic [WORD_W-1:0]    LAST_WORD = WORD_W'(ROW_WORDS - 1);

  function automatic logic word_full(input logic [BYTE_WIDTH*NUM_BYTES-1:0] d,
                                     input logic [NUM_BYTES-1:0] m);
    logic f;
    f = 1'b1;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (m[i] && (d[i*BYTE_WIDTH +: BYTE_WIDTH] == BYTE_WIDTH'(EMPTY_CELL))) f = 1'b0;
    end
    return f;
  endfunction

  lce_state_e        r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_cur;
  logic [LC_W-1:0]   r_lines;
  logic              r_rd_pend, r_rd_done, r_full;
  logic [WORD_W-1:0] r_ret_word;

  logic             w_issue, w_wrap, w_rd_load, w_wr_load, w_wr_adv;
  logic [ROW_W-1:0] w_rd_row, w_wr_row, w_rd_row_cur, w_wr_row_cur;
  logic             w_rd_last, w_wr_last, w_acc;
  logic             w_restart, w_cur_init, w_cur_dec, w_lines_clr, w_lines_inc;

  line_clear_addr_gen #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .BASE_ADDR    (BASE_ADDR),
    .ROW_WORDS    (ROW_WORDS),
    .ROW_W        (ROW_W),
    .WORD_W       (WORD_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_rd_load(w_rd_load),
    .i_rd_row (w_rd_row),
    .i_rd_adv (w_issue),
    .i_rd_wrap(w_wrap),
    .i_wr_load(w_wr_load),
    .i_wr_row (w_wr_row),
    .i_wr_adv (w_wr_adv),
    .i_wr_wrap(w_wrap),
    .o_rd_row (w_rd_row_cur),
    .o_rd_last(w_rd_last),
    .o_wr_row (w_wr_row_cur),
    .o_wr_last(w_wr_last),
    .o_raddr  (raddr),
    .o_waddr  (waddr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cur      <= '0;
      r_lines    <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_full     <= 1'b0;
      r_ret_word <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_issue;
      if (w_cur_init)     r_cur <= ROW_W'(ROWS - 1);
      else if (w_cur_dec) r_cur <= r_cur - ROW_W'(1);
      if (w_lines_clr)      r_lines <= '0;
      else if (w_lines_inc) r_lines <= r_lines + LC_W'(1);
      if (w_restart) begin
        r_full     <= 1'b1;
        r_ret_word <= '0;
        r_rd_done  <= 1'b0;
      end else begin
        // SCAN stops after one row; SHIFT streams until row 0's last word is read.
        if (w_issue && w_rd_last && (r_state == ST_SCAN || w_rd_row_cur == '0))
          r_rd_done <= 1'b1;
        if (r_rd_pend && r_state == ST_SCAN) begin
          r_full     <= w_acc;
          r_ret_word <= r_ret_word + WORD_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_wrap      = 1'b0;
    w_rd_load   = 1'b0;
    w_rd_row    = r_cur;
    w_wr_load   = 1'b0;
    w_wr_row    = '0;
    w_wr_adv    = 1'b0;
    w_restart   = 1'b0;
    w_cur_init  = 1'b0;
    w_cur_dec   = 1'b0;
    w_lines_clr = 1'b0;
    w_lines_inc = 1'b0;
    w_acc       = r_full & word_full(q, (r_ret_word == LAST_WORD) ? LAST_BE : FULL_BE);
    busy        = 1'b0;
    done        = 1'b0;
    we          = 1'b0;
    be          = '0;
    wdata       = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SCAN;
          w_cur_init  = 1'b1;
          w_lines_clr = 1'b1;
          w_restart   = 1'b1;
          w_rd_load   = 1'b1;
          w_rd_row    = ROW_W'(ROWS - 1);
        end
      end
      ST_SCAN: begin
        busy    = 1'b1;
        w_issue = mem_gnt & ~r_rd_done;
        if (r_rd_pend && r_ret_word == LAST_WORD) begin
          if (w_acc) begin
            w_wr_load = 1'b1;
            if (r_cur == '0) begin
              w_state_nxt = ST_CLEAR;
            end else begin
              w_state_nxt = ST_SHIFT;
              w_wr_row    = r_cur;
              w_rd_load   = 1'b1;
              w_rd_row    = r_cur - ROW_W'(1);
              w_restart   = 1'b1;
            end
          end else if (r_cur == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_cur_dec = 1'b1;
            w_rd_load = 1'b1;
            w_rd_row  = r_cur - ROW_W'(1);
            w_restart = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        busy     = 1'b1;
        w_wrap   = 1'b1;
        w_issue  = mem_gnt & ~r_rd_done;
        we       = r_rd_pend;
        w_wr_adv = r_rd_pend;
        be       = r_rd_pend ? (w_wr_last ? LAST_BE : FULL_BE) : '0;
        wdata    = r_rd_pend ? q : '0;
        if (r_rd_pend && w_wr_row_cur == ROW_W'(1) && w_wr_last) begin
          w_state_nxt = ST_CLEAR;
          w_wr_load   = 1'b1;
        end
      end
      ST_CLEAR: begin
        busy     = 1'b1;
        we       = 1'b1;
        w_wr_adv = 1'b1;
        be       = w_wr_last ? LAST_BE : FULL_BE;
        wdata    = {NUM_BYTES{BYTE_WIDTH'(EMPTY_CELL)}};
        if (w_wr_last) begin
          w_state_nxt = ST_SCAN;
          w_lines_inc = 1'b1;
          w_rd_load   = 1'b1;
          w_restart   = 1'b1;
        end
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign lines_cleared = r_lines;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench: a board-level model predicts each pass; a monitor checks on done.
module tb_line_clear_engine;

  localparam int AW = 12, BW = 8, NB = 4, ROWS = 20, COLS = 10;
  localparam int RW = (COLS + NB - 1) / NB;
  localparam int NW = ROWS * RW;
  localparam int LCW = $clog2(ROWS + 1);

  logic           clk = 1'b0, reset_n = 1'b0, start = 1'b0, mem_gnt = 1'b0;
  logic           busy, done, we;
  logic [LCW-1:0] lines_cleared;
  logic [AW-1:0]  raddr, waddr;
  logic [31:0]    q, wdata;
  logic [NB-1:0]  be;

  line_clear_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .mem_gnt(mem_gnt), .raddr(raddr), .q(q),
    .we(we), .waddr(waddr), .be(be), .wdata(wdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [NW];
  logic [31:0] img [NW];
  logic        ld = 1'b0;
  logic [31:0] q_r = '0;
  assign q = q_r;

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < NW; i++) mem[i] <= img[i];
    end else if (we && int'(waddr) < NW) begin
      for (int i = 0; i < NB; i++)
        if (be[i]) mem[waddr][i*BW +: BW] <= wdata[i*BW +: BW];
    end
    q_r <= (int'(raddr) < NW) ? mem[raddr] : '0;
  end

  int   gmode = 0;
  logic gt = 1'b0;
  always @(posedge clk) begin
    #2;
    case (gmode)
      1:       begin gt = ~gt; mem_gnt = gt; end
      2:       mem_gnt = 1'($urandom_range(0, 1));
      default: mem_gnt = 1'b1;
    endcase
  end

  int n_tests = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0]      lines;
    logic [31:0]      writes;
    logic [31:0]      cycles;
    logic             chk_cyc;
    logic [NW*32-1:0] img;
  } exp_t;
  exp_t q_exp[$];

  function automatic logic [7:0] cellof(input int r, input int c);
    return img[r*RW + c/NB][(c%NB)*BW +: BW];
  endfunction

  // Result of removing every full row and letting the rest fall; padding is untouched.
  function automatic exp_t model(input logic chkc);
    exp_t        e;
    int          keep[$];
    int          full[$];
    logic [31:0] im[NW];
    logic [7:0]  v;
    bit          f;
    int          d, dst, idx;
    for (int r = ROWS - 1; r >= 0; r--) begin
      f = 1;
      for (int c = 0; c < COLS; c++) if (cellof(r, c) == 8'h00) f = 0;
      if (f) full.push_back(r); else keep.push_back(r);
    end
    for (int i = 0; i < NW; i++) im[i] = img[i];
    for (int k = 0; k < ROWS; k++) begin
      dst = ROWS - 1 - k;
      for (int c = 0; c < COLS; c++) begin
        v   = (k < keep.size()) ? cellof(keep[k], c) : 8'h00;
        idx = dst*RW + c/NB;
        im[idx][(c%NB)*BW +: BW] = v;
      end
    end
    e.lines   = full.size();
    e.writes  = 0;
    e.cycles  = (ROWS + full.size()) * (RW + 1) + full.size() * RW;
    e.chk_cyc = chkc;
    for (int j = 0; j < full.size(); j++) begin
      d = full[j] + j;
      e.writes = e.writes + (d + 1) * RW;
      if (d > 0) e.cycles = e.cycles + d * RW + 1;
    end
    for (int i = 0; i < NW; i++) e.img[i*32 +: 32] = im[i];
    return e;
  endfunction

  int   bcnt = 0, wcnt = 0, viol = 0, n_done = 0, bad, first_bad;
  logic prev_gnt = 1'b0;
  exp_t e_mon;
  always @(negedge clk) begin
    if (!reset_n) begin
      bcnt = 0; wcnt = 0; viol = 0; prev_gnt = 1'b0;
    end else begin
      if (busy) bcnt++;
      if (we) begin
        wcnt++;
        if (int'(waddr) >= RW && !prev_gnt) viol++;
      end
      if (done) begin
        if (q_exp.size() == 0) begin
          chk("unexpected_done", 64'(q_exp.size()), 64'd1);
        end else begin
          e_mon = q_exp.pop_front();
          chk("lines_cleared", 64'(lines_cleared), 64'(e_mon.lines));
          chk("write_count", 64'(wcnt), 64'(e_mon.writes));
          if (e_mon.chk_cyc) chk("busy_cycles", 64'(bcnt), 64'(e_mon.cycles));
          chk("write_without_granted_read", 64'(viol), 64'd0);
          bad = 0; first_bad = -1;
          for (int i = 0; i < NW; i++)
            if (mem[i] !== e_mon.img[i*32 +: 32]) begin
              bad++;
              if (first_bad < 0) first_bad = i;
            end
          chk($sformatf("ram_image(bad words, first at %0d)", first_bad), 64'(bad), 64'd0);
        end
        bcnt = 0; wcnt = 0; viol = 0;
        n_done++;
      end
      prev_gnt = mem_gnt;
    end
  end

  task automatic blank_img();
    for (int i = 0; i < NW; i++) img[i] = '0;
    for (int r = 0; r < ROWS; r++)
      for (int b = COLS; b < RW*NB; b++)
        img[r*RW + b/NB][(b%NB)*BW +: BW] = 8'($urandom_range(1, 255));
  endtask

  task automatic set_row_full(input int r, input logic [7:0] v);
    for (int c = 0; c < COLS; c++) img[r*RW + c/NB][(c%NB)*BW +: BW] = v;
  endtask

  task automatic rand_img();
    bit fr;
    blank_img();
    for (int r = 0; r < ROWS; r++) begin
      fr = ($urandom_range(0, 99) < 35);
      for (int c = 0; c < COLS; c++)
        img[r*RW + c/NB][(c%NB)*BW +: BW] =
          (fr || $urandom_range(0, 2) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    end
  endtask

  task automatic load_img();
    @(negedge clk) ld = 1'b1;
    @(negedge clk) ld = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_pass(input int gm);
    int n0;
    gmode = gm;
    load_img();
    q_exp.push_back(model(gm == 0));
    n0 = n_done;
    pulse_start();
    for (int i = 0; i < 8000; i++) begin
      if (n_done != n0) break;
      @(negedge clk);
    end
    if (n_done == n0) begin
      chk("done_timeout", 64'(n_done - n0), 64'd1);
      q_exp.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] pad19;
    int          seen;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_we", 64'(we), 64'd0);
    chk("rst_be", 64'(be), 64'd0);
    chk("rst_raddr", 64'(raddr), 64'd0);
    chk("rst_waddr", 64'(waddr), 64'd0);
    chk("rst_wdata", 64'(wdata), 64'd0);
    chk("rst_lines", 64'(lines_cleared), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    blank_img();
    run_pass(0);

    blank_img();
    set_row_full(19, 8'h03);
    img[18*RW][7:0] = 8'h05;
    pad19 = img[19*RW + RW - 1][31:16];
    run_pass(0);
    chk("row19_word0", 64'(mem[19*RW]), 64'h5);
    chk("row19_padding", 64'(mem[19*RW + RW - 1][31:16]), 64'(pad19));

    blank_img();
    for (int r = 16; r < 20; r++) set_row_full(r, 8'($urandom_range(1, 255)));
    run_pass(0);

    blank_img();
    set_row_full(0, 8'h07);
    run_pass(0);

    blank_img();
    set_row_full(19, 8'h03);
    img[18*RW][7:0] = 8'h05;
    run_pass(1);

    blank_img();
    set_row_full(19, 8'h0a);
    set_row_full(12, 8'h0b);
    gmode = 0;
    load_img();
    pulse_start();
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (we) begin seen = 1; break; end
    end
    chk("shift_write_seen", 64'(seen), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_we", 64'(we), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_pass(0);

    for (int t = 0; t < 8; t++) begin
      rand_img();
      run_pass(($urandom_range(0, 1) == 0) ? 0 : 2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
